// File: rtl/bf16_lane_issuer.sv
// Operand issuer and result collector for one BF16 compute lane.
// Reads are throttled by a credit count so results from the non-stallable lane always fit the FIFO.
module bf16_lane_issuer #(
    parameter int ADDR_W     = 10,
    parameter int LEN_W      = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op_mode,
    input  logic              relu_en,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  vec_len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [47:0]       rd_data,
    output logic              lane_en,
    output logic [15:0]       lane_a,
    output logic [15:0]       lane_b,
    output logic [15:0]       lane_c,
    output logic [2:0]        lane_op,
    output logic              lane_relu,
    input  logic [15:0]       lane_res,
    input  logic              lane_rdy,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic              res_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               relu_q, relu_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   issued_q, issued_d;
    logic [LEN_W-1:0]   popped_q, popped_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               lane_en_q, lane_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [15:0]        mem_q [FIFO_DEPTH];

    logic               push;
    logic               pop;
    logic               issue;
    logic [CNT_W:0]     credit_used;

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        relu_d        = relu_q;
        base_d        = base_q;
        len_d         = len_q;
        issued_d      = issued_q;
        popped_d      = popped_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        rd_en_d       = 1'b0;
        rd_addr_d     = rd_addr_q;

        push          = lane_rdy && (outstanding_q != '0);
        pop           = (fifo_cnt_q != '0) && res_ready;
        // Credit counts reads in flight from the moment of issue, so the FIFO can never overflow.
        credit_used   = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
        issue         = (state_q == S_RUN) && (issued_q < len_q)
                        && (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op_mode;
                    relu_d   = relu_en;
                    base_d   = base_addr;
                    len_d    = vec_len;
                    issued_d = '0;
                    popped_d = '0;
                    state_d  = (vec_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue && (issued_q == len_q - LEN_W'(1))) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && (popped_q == len_q - LEN_W'(1))) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            rd_en_d   = 1'b1;
            rd_addr_d = base_q + ADDR_W'(issued_q);
            issued_d  = issued_q + LEN_W'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            popped_d = popped_q + LEN_W'(1);
        end

        outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(push);
        fifo_cnt_d    = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        lane_en_d     = rd_en_q;
        busy_d        = (state_d != S_IDLE);
        done_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            relu_q        <= 1'b0;
            base_q        <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            popped_q      <= '0;
            outstanding_q <= '0;
            fifo_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            rd_en_q       <= 1'b0;
            rd_addr_q     <= '0;
            lane_en_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            relu_q        <= relu_d;
            base_q        <= base_d;
            len_q         <= len_d;
            issued_q      <= issued_d;
            popped_q      <= popped_d;
            outstanding_q <= outstanding_d;
            fifo_cnt_q    <= fifo_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_en_q       <= rd_en_d;
            rd_addr_q     <= rd_addr_d;
            lane_en_q     <= lane_en_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= lane_res;
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && (fifo_cnt_q == CNT_W'(FIFO_DEPTH))));

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign lane_en   = lane_en_q;
    // Operands are forced to zero outside issue cycles so nothing leaks from a stale RAM word.
    assign lane_a    = lane_en_q ? rd_data[47:32] : '0;
    assign lane_b    = lane_en_q ? rd_data[31:16] : '0;
    assign lane_c    = lane_en_q ? rd_data[15:0]  : '0;
    assign lane_op   = op_q;
    assign lane_relu = relu_q;
    assign res_valid = (fifo_cnt_q != '0);
    assign res_data  = res_valid ? mem_q[rd_ptr_q] : '0;
    assign res_last  = res_valid && (popped_q == len_q - LEN_W'(1));

endmodule

// File: tb/tb_bf16_lane_issuer.sv
// Scoreboard bench for bf16_lane_issuer with a behavioural operand RAM and a 2-cycle BF16 lane stub.
module tb_bf16_lane_issuer;

    localparam int ADDR_W = 10;
    localparam int LEN_W  = 10;
    localparam int DEPTH  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [2:0]        op_mode = '0;
    logic              relu_en = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  vec_len = '0;
    logic              busy, done, rd_en, lane_en, lane_relu, lane_rdy;
    logic              res_valid, res_last;
    logic              res_ready = 1'b1;
    logic [ADDR_W-1:0] rd_addr;
    logic [47:0]       rd_data = '0;
    logic [15:0]       lane_a, lane_b, lane_c, lane_res, res_data;
    logic [2:0]        lane_op;

    bf16_lane_issuer #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .op_mode(op_mode), .relu_en(relu_en),
        .base_addr(base_addr), .vec_len(vec_len), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .lane_en(lane_en),
        .lane_a(lane_a), .lane_b(lane_b), .lane_c(lane_c), .lane_op(lane_op),
        .lane_relu(lane_relu), .lane_res(lane_res), .lane_rdy(lane_rdy),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
    );

    int CHECKS = 0;
    int ERRORS = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        CHECKS++;
        if (act !== exp) begin
            ERRORS++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // BF16 arithmetic through double precision, truncated back to BF16.
    function automatic real bf2r(input logic [15:0] h);
        logic [63:0] bits;
        if (h[14:7] == 8'd0) return 0.0;
        bits = {h[15], 11'(int'(h[14:7]) + 896), h[6:0], 45'd0};
        return $bitstoreal(bits);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] bits;
        int e;
        bits = $realtobits(r);
        e = int'(bits[62:52]) - 1023 + 127;
        if (e <= 0) return 16'h0000;
        if (e >= 255) return {bits[63], 8'hFF, 7'h00};
        return {bits[63], e[7:0], bits[51:45]};
    endfunction

    function automatic logic [15:0] lane_fn(input logic [2:0] op, input logic relu,
                                            input logic [15:0] a, input logic [15:0] b,
                                            input logic [15:0] c);
        real r;
        logic [15:0] res;
        case (op)
            3'd0:    r = bf2r(a) + bf2r(b);
            3'd1:    r = bf2r(a) * bf2r(b);
            default: r = bf2r(a) * bf2r(b) + bf2r(c);
        endcase
        res = r2bf(r);
        if (relu && res[15]) res = 16'h0000;
        return res;
    endfunction

    function automatic logic [15:0] rand_bf();
        logic [15:0] v;
        v[15]   = 1'($urandom_range(0, 1));
        v[14:7] = 8'($urandom_range(110, 140));
        v[6:0]  = 7'($urandom);
        return v;
    endfunction

    // Operand RAM: one cycle read latency.
    logic [47:0] ram [1024];
    always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

    // Lane stub: fixed 2-cycle latency, flushed by rst; spur injects lane_rdy with nothing in flight.
    logic        s1v = 1'b0, s2v = 1'b0, spur = 1'b0;
    logic [15:0] s1d = '0, s2d = '0;
    always @(posedge clk) begin
        if (rst) begin
            s1v <= 1'b0;
            s2v <= 1'b0;
        end else begin
            s1v <= lane_en;
            s1d <= lane_fn(lane_op, lane_relu, lane_a, lane_b, lane_c);
            s2v <= s1v;
            s2d <= s1d;
        end
    end
    assign lane_rdy = s2v | spur;
    assign lane_res = spur ? 16'hDEAD : s2d;

    typedef struct { logic [15:0] data; logic last; } exp_t;
    exp_t              sb[$];
    logic [ADDR_W-1:0] addr_log[$];
    int                done_cnt = 0;
    int                rd_run = 0;
    int                max_run = 0;
    logic              hold_v = 1'b0;
    logic [15:0]       hold_d = '0;
    logic [15:0]       last_pop = '0;

    always @(negedge clk) begin
        if (rst) begin
            rd_run = 0;
            hold_v = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (rd_en) begin
                addr_log.push_back(rd_addr);
                rd_run++;
                if (rd_run > max_run) max_run = rd_run;
            end else begin
                rd_run = 0;
            end
            if (hold_v) chk("res_hold", {47'd0, res_valid, res_data}, {47'd0, 1'b1, hold_d});
            if (res_valid && res_ready) begin
                if (sb.size() == 0) begin
                    CHECKS++;
                    ERRORS++;
                    $display("FAIL unexpected_res: got %0h expected none at %0t", res_data, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("res_data", 64'(res_data), 64'(e.data));
                    chk("res_last", 64'(res_last), 64'(e.last));
                    last_pop = res_data;
                end
            end
            hold_v = res_valid && !res_ready;
            hold_d = res_data;
        end
    end

    int cur_mode = 0;     // 0: ready high, 1: random ready, 2: stall then release
    int job_mode = 0;
    int job_done0 = 0;
    int exp_base = 0;
    int exp_len = 0;

    function automatic logic next_ready();
        if (cur_mode == 0) return 1'b1;
        if (cur_mode == 1) return 1'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    task automatic start_job(input int op, input int relu, input int base, input int len, input int mode);
        addr_log.delete();
        max_run = 0;
        job_done0 = done_cnt;
        cur_mode = mode;
        job_mode = mode;
        exp_base = base;
        exp_len = len;
        for (int i = 0; i < len; i++) begin
            exp_t e;
            logic [47:0] w;
            w = ram[(base + i) % 1024];
            e.data = lane_fn(3'(op), 1'(relu), w[47:32], w[31:16], w[15:0]);
            e.last = (i == len - 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        op_mode = 3'(op); relu_en = 1'(relu); base_addr = ADDR_W'(base); vec_len = LEN_W'(len);
        start = 1'b1;
        res_ready = next_ready();
        @(posedge clk); #1;
        start = 1'b0;
        res_ready = next_ready();
    endtask

    task automatic finish_job();
        int c;
        int n;
        if (cur_mode == 2) begin
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                res_ready = 1'b0;
                // A start while busy must be ignored and must not disturb the latched job.
                start = (k == 10);
                if (k == 10) begin
                    op_mode = 3'(op_mode + 3'd1);
                    vec_len = LEN_W'(5);
                    base_addr = ADDR_W'(base_addr + 10'd7);
                end
            end
            start = 1'b0;
            chk("stall_issues", 64'(addr_log.size()), 64'((exp_len < DEPTH) ? exp_len : DEPTH));
            cur_mode = 0;
        end
        c = 0;
        while (done_cnt == job_done0 && c < 3000) begin
            @(posedge clk); #1;
            res_ready = next_ready();
            c++;
        end
        cur_mode = 0;
        res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_pulses", 64'(done_cnt - job_done0), 64'd1);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("rd_count", 64'(addr_log.size()), 64'(exp_len));
        n = (addr_log.size() < exp_len) ? addr_log.size() : exp_len;
        for (int i = 0; i < n; i++)
            chk("rd_addr", 64'(addr_log[i]), 64'((exp_base + i) % 1024));
        if (job_mode == 0) chk("rd_burst", 64'(max_run), 64'(exp_len));
    endtask

    task automatic run_job(input int op, input int relu, input int base, input int len, input int mode);
        start_job(op, relu, base, len, mode);
        finish_job();
    endtask

    initial begin
        int b;
        for (int i = 0; i < 1024; i++) ram[i] = {rand_bf(), rand_bf(), rand_bf()};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outs", {46'd0, busy, done, rd_en, lane_en, res_valid, res_last, 8'd0, rd_addr},
            64'd0);

        b = 37;
        ram[b] = {16'h3F80, 16'h4000, 16'h0000};
        run_job(0, 0, b, 1, 0);
        chk("add_val", 64'(last_pop), 64'h4040);

        b = 100;
        ram[b] = {16'h4000, 16'h4040, rand_bf()};
        run_job(1, 0, b, 1, 0);
        chk("mul_val", 64'(last_pop), 64'h40C0);

        b = 200;
        ram[b] = {16'h4000, 16'h4040, 16'h3F80};
        run_job(2, 0, b, 1, 0);
        chk("fma_val", 64'(last_pop), 64'h40E0);

        b = 300;
        ram[b] = {16'hBF80, 16'h0000, rand_bf()};
        run_job(0, 1, b, 1, 0);
        chk("relu_val", 64'(last_pop), 64'h0000);

        run_job(2, 0, 400, 20, 0);
        run_job(1, 1, 500, 20, 2);
        run_job(0, 0, 10'h3FE, 4, 0);

        // Zero-length job: done follows the accepting edge, no reads, no results.
        addr_log.delete();
        job_done0 = done_cnt;
        @(posedge clk); #1;
        vec_len = '0; start = 1'b1;
        @(negedge clk);
        chk("len0_pre", {62'd0, busy, done}, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("len0_done", {62'd0, busy, done}, 64'd3);
        @(negedge clk);
        chk("len0_after", {62'd0, busy, done}, 64'd0);
        chk("len0_reads", 64'(addr_log.size()), 64'd0);
        chk("len0_pulses", 64'(done_cnt - job_done0), 64'd1);

        // Spurious lane_rdy while nothing is outstanding must not create a result.
        @(posedge clk); #1 spur = 1'b1;
        repeat (2) @(posedge clk);
        #1 spur = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("spur_ignored", 64'(res_valid), 64'd0);

        // Reset while draining: results are discarded and no done pulse appears.
        start_job(0, 0, 600, 4, 2);
        repeat (15) @(posedge clk);
        #1 chk("drain_pre", {62'd0, busy, res_valid}, 64'd3);
        job_done0 = done_cnt;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        cur_mode = 0;
        res_ready = 1'b1;
        chk("rst_outs", {46'd0, busy, done, rd_en, lane_en, res_valid, res_last, 8'd0, rd_addr},
            64'd0);
        repeat (4) @(posedge clk);
        #1 chk("rst_no_done", 64'(done_cnt - job_done0), 64'd0);
        run_job(1, 0, 700, 6, 0);

        for (int j = 0; j < 6; j++)
            run_job($urandom_range(0, 2), $urandom_range(0, 1), $urandom_range(0, 1023),
                    $urandom_range(1, 40), $urandom_range(0, 2));

        $display("CHECKS %0d ERRORS %0d", CHECKS, ERRORS);
        $finish;
    end

endmodule
